arith_seq: RTL and testbench



---
 rtl/arith_seq.sv | 189 ++++++++++++++++++
 tb/tb_arith_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/arith_seq.sv
// Multi-cycle unsigned arithmetic unit: add, shift-add multiply, absolute difference and
// restoring divide/remainder behind a start/busy/done handshake.
module arith_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] outau,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpMul = 3'b001;
    localparam logic [2:0] OpAbs = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpRem = 3'b100;

    localparam logic [WIDTH-1:0] MsbOnly = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StExec, StIter} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    // acc: product high half or partial remainder; sh: multiplier or dividend/quotient
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] outau_d;
    logic             done_d, err_d, ovf_d;

    logic [WIDTH-1:0]   mx, mn;
    logic               is_div, zero_div, iter_go;
    logic [WIDTH:0]     add_sum, mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_bit;
    logic [WIDTH-1:0]   rem_next, quo_next;

    assign busy     = (state_q != StIdle);
    assign mx       = (a_q >= b_q) ? a_q : b_q;
    assign mn       = (a_q >= b_q) ? b_q : a_q;
    assign is_div   = (op_q == OpDiv) || (op_q == OpRem);
    assign zero_div = (mn == '0);
    assign iter_go  = (op_q == OpMul) || (is_div && !zero_div);
    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};

    assign mul_sum  = sh_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    assign mul_next = {mul_sum, sh_q[WIDTH-1:1]};

    assign div_shift = {acc_q, sh_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    // Quotient bit is set when the trial difference is non-negative and fits the remainder
    assign div_bit   = (div_diff[WIDTH+1:WIDTH] == 2'b00);
    assign rem_next  = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {sh_q[WIDTH-2:0], div_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StExec;
            StExec:  state_d = iter_go ? StIter : StIdle;
            StIter:  if (cnt_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        outau_d = outau;
        err_d   = err;
        ovf_d   = ovf;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = opcode;
                end
            end
            StExec: begin
                acc_d = '0;
                cnt_d = CW'(WIDTH - 1);
                if (op_q == OpMul) begin
                    sh_d   = b_q;
                    opnd_d = a_q;
                end else begin
                    sh_d   = mx;
                    opnd_d = mn;
                end
                if (!iter_go) begin
                    done_d = 1'b1;
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    case (op_q)
                        OpAdd: begin
                            outau_d = add_sum[WIDTH-1:0];
                            ovf_d   = add_sum[WIDTH];
                        end
                        OpAbs: outau_d = mx - mn;
                        OpDiv, OpRem: begin
                            outau_d = MsbOnly;
                            err_d   = 1'b1;
                        end
                        default: outau_d = '0;
                    endcase
                end
            end
            StIter: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OpMul) begin
                    {acc_d, sh_d} = mul_next;
                end else begin
                    acc_d = rem_next;
                    sh_d  = quo_next;
                end
                if (cnt_q == '0) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (op_q == OpMul) begin
                        outau_d = mul_next[WIDTH-1:0];
                        ovf_d   = |mul_next[2*WIDTH-1:WIDTH];
                    end else if (op_q == OpDiv) begin
                        outau_d = quo_next;
                    end else begin
                        outau_d = rem_next;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            outau  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            outau  <= outau_d;
            done   <= done_d;
            err    <= err_d;
            ovf    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_arith_seq.sv
// Scoreboard bench for arith_seq: a 32-bit instance with directed and random traffic and an
// 8-bit instance for the start-held-high sequence; a negedge monitor checks every done.
module tb_arith_seq;

    typedef struct {
        longint unsigned res;
        bit              e;
        bit              o;
        int              due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, outau32;
    logic [7:0]  a8 = '0, b8 = '0, outau8;
    logic [2:0]  opcode32 = '0, opcode8 = '0;
    logic        busy32, done32, err32, ovf32;
    logic        busy8, done8, err8, ovf8;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;

    arith_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .opcode(opcode32),
        .outau(outau32), .busy(busy32), .done(done32), .err(err32), .ovf(ovf32)
    );

    arith_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .opcode(opcode8),
        .outau(outau8), .busy(busy8), .done(done8), .err(err8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the operation rules in plain 64-bit arithmetic
    function automatic void model(input int w, input bit [2:0] op, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned res,
                                  output bit e, output bit o, output int lat);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned mx = (a > b) ? a : b;
        longint unsigned mn = (a > b) ? b : a;
        longint unsigned full;
        res = 0; e = 0; o = 0; lat = 1;
        case (op)
            3'd0: begin full = a + b; res = full & mask; o = (full >> w) != 0; end
            3'd1: begin full = a * b; res = full & mask; o = (full >> w) != 0; lat = w + 1; end
            3'd2: res = mx - mn;
            3'd3, 3'd4: begin
                if (mn == 0) begin
                    res = 64'd1 << (w - 1);
                    e   = 1;
                end else begin
                    res = (op == 3'd3) ? mx / mn : mx % mn;
                    lat = w + 1;
                end
            end
            default: res = 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL w32 unexpected done: outau=%0h, expected no done", outau32);
            end else begin
                m32 = q32.pop_front();
                chk("w32 outau", outau32, m32.res);
                chk("w32 err", err32, m32.e);
                chk("w32 ovf", ovf32, m32.o);
                chk("w32 done cycle", cyc, m32.due);
                chk("w32 busy in done", busy32, 0);
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL w8 unexpected done: outau=%0h, expected no done", outau8);
            end else begin
                m8 = q8.pop_front();
                chk("w8 outau", outau8, m8.res);
                chk("w8 err", err8, m8.e);
                chk("w8 ovf", ovf8, m8.o);
                chk("w8 done cycle", cyc, m8.due);
            end
        end
    end

    // Waits for idle (poking ignored junk starts while busy), then issues one operation
    task automatic issue32(input bit [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        longint unsigned r;
        bit ee, oo;
        int lat;
        int guard = 0;
        @(negedge clk);
        while (busy32 && guard < 100) begin
            start32  = 1'($urandom_range(0, 1));
            a32      = $urandom;
            b32      = $urandom;
            opcode32 = 3'($urandom);
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL w32 busy timeout: busy=%0b, expected 0", busy32);
        end
        start32 = 1'b1; a32 = av; b32 = bv; opcode32 = op;
        model(32, op, longint'(av), longint'(bv), r, ee, oo, lat);
        e.res = r; e.e = ee; e.o = oo; e.due = cyc + 1 + lat;
        q32.push_back(e);
        @(posedge clk);
        #1 start32 = 1'b0;
    endtask

    task automatic push8(input bit [2:0] op, input int av, input int bv, input int due);
        exp_t e;
        longint unsigned r;
        bit ee, oo;
        int lat;
        model(8, op, longint'(av), longint'(bv), r, ee, oo, lat);
        e.res = r; e.e = ee; e.o = oo; e.due = due;
        q8.push_back(e);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int k, g;

        #1 rst = 1'b1;
        #2;
        chk("reset outau32", outau32, 0);
        chk("reset busy32", busy32, 0);
        chk("reset done32", done32, 0);
        chk("reset err32", err32, 0);
        chk("reset ovf32", ovf32, 0);
        chk("reset outau8", outau8, 0);
        chk("reset busy8", busy8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue32(3'b000, 32'hFFFF_FFFF, 32'd2);
        issue32(3'b001, 32'h1_0000, 32'h1_0000);
        issue32(3'b001, 32'd1234, 32'd5678);
        issue32(3'b011, 32'd7, 32'd100);
        issue32(3'b100, 32'd7, 32'd100);
        issue32(3'b011, 32'd0, 32'd5);
        issue32(3'b010, 32'd3, 32'd10);
        issue32(3'b010, 32'd10, 32'd3);
        issue32(3'b110, 32'd55, 32'd66);

        // 8-bit unit with start held high: div accepted, add waits for the done cycle
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd7; opcode8 = 3'b011;
        k = cyc + 1;
        push8(3'b011, 200, 7, k + 9);
        @(posedge clk);
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; opcode8 = 3'b000;
        push8(3'b000, 1, 1, k + 11);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = '0;
                2: rb = ra;
                3: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                default: ;
            endcase
            issue32(3'($urandom_range(0, 7)), ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Abort a multiply with reset part-way through
        issue32(3'b010, 32'd3, 32'd10);
        issue32(3'b001, $urandom, $urandom);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort outau32", outau32, 0);
        chk("abort busy32", busy32, 0);
        chk("abort done32", done32, 0);
        chk("abort err32", err32, 0);
        chk("abort ovf32", ovf32, 0);
        q32.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue32(3'b000, 32'd4, 32'd5);

        g = 0;
        while ((q32.size() != 0 || q8.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("w32 pending results", q32.size(), 0);
        chk("w8 pending results", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
